ex_stage_ctrl: RTL

- Execute-stage controller for the RV32I core; sits between decode and the combinational ALU.
- Maps decoded instruction fields onto ALU operands and control, and derives SLT/SLTU and branch decisions from the ALU flags.
- Registers result, destination and branch outcome into a one-deep EX/MEM output register with valid/ready handshake.

---
 rtl/rv32i_pkg.sv | 41 ++++
 rtl/ex_branch_unit.sv | 30 +++
 rtl/ex_stage_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I execute-stage constants: opcodes, ALU op codes, funct3 codes, flag indices.
package rv32i_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;  // or when alu_sign=1
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_SRA = 3'b100;
  localparam logic [2:0] ALU_SLA = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int FLAG_N = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/ex_branch_unit.sv
// Branch condition evaluation from ALU flags (rs1-rs2) and a local unsigned compare.
module ex_branch_unit
  import rv32i_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [2:0] flags,
  input  logic       ltu,
  output logic       taken,
  output logic       illegal
);

  logic lt;

  assign lt = flags[FLAG_N] ^ flags[FLAG_V];

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    case (funct3)
      F3_BEQ:  taken = flags[FLAG_Z];
      F3_BNE:  taken = ~flags[FLAG_Z];
      F3_BLT:  taken = lt;
      F3_BGE:  taken = ~lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = ~ltu;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_stage_ctrl.sv
// RV32I execute-stage controller: drives the external ALU, resolves SLT/branches,
// and holds the outcome in a one-deep EX/MEM register with valid/ready handshake.
module ex_stage_ctrl
  import rv32i_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RESET_PC_OFS = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic            flush_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [4:0]      rd_i,
  output logic [XLEN-1:0] alu_src_a_o,
  output logic [XLEN-1:0] alu_src_b_o,
  output logic            alu_sign_o,
  output logic [2:0]      alu_control_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [2:0]      alu_flags_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] ex_result_o,
  output logic [4:0]      ex_rd_o,
  output logic            ex_wen_o,
  output logic            br_taken_o,
  output logic [XLEN-1:0] br_target_o,
  output logic            illegal_o
);

  logic            is_imm;
  logic            sub_sel;
  logic            sra_sel;
  logic            ltu;
  logic            slt;
  logic            accept;
  logic            br_taken;
  logic            br_illegal;
  logic [XLEN-1:0] link;
  logic [XLEN-1:0] pc_imm;
  logic [XLEN-1:0] nxt_result;
  logic [XLEN-1:0] nxt_target;
  logic            nxt_wen;
  logic            nxt_taken;
  logic            nxt_illegal;

  assign is_imm  = (opcode_i == OPC_OPIMM);
  assign sub_sel = ~is_imm & funct7_5_i;
  // srai is distinguished by imm[10] (instr[30] folded into the immediate)
  assign sra_sel = is_imm ? imm_i[10] : funct7_5_i;
  assign ltu     = (rs1_data_i < alu_src_b_o);
  assign slt     = alu_flags_i[FLAG_N] ^ alu_flags_i[FLAG_V];
  assign link    = pc_i + XLEN'(RESET_PC_OFS);
  assign pc_imm  = pc_i + imm_i;

  ex_branch_unit u_branch (
    .funct3  (funct3_i),
    .flags   (alu_flags_i),
    .ltu     (ltu),
    .taken   (br_taken),
    .illegal (br_illegal)
  );

  always_comb begin
    alu_src_a_o   = rs1_data_i;
    alu_src_b_o   = rs2_data_i;
    alu_control_o = ALU_ADD;
    alu_sign_o    = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OPIMM: begin
        alu_src_b_o = is_imm ? imm_i : rs2_data_i;
        case (funct3_i)
          F3_ADD: begin
            alu_control_o = sub_sel ? ALU_SUB : ALU_ADD;
            alu_sign_o    = sub_sel;
          end
          F3_SLL: begin
            alu_control_o = ALU_SLL;
            alu_sign_o    = is_imm;
          end
          F3_SLT, F3_SLTU: begin
            alu_control_o = ALU_SUB;
            alu_sign_o    = 1'b1;
          end
          F3_XOR: begin
            alu_control_o = ALU_XOR;
            alu_sign_o    = is_imm;
          end
          F3_SR: begin
            alu_control_o = sra_sel ? ALU_SRA : ALU_SRL;
            alu_sign_o    = is_imm;
          end
          F3_OR: begin
            alu_control_o = ALU_AND;
            alu_sign_o    = 1'b1;
          end
          default: alu_control_o = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        alu_src_a_o = '0;
        alu_src_b_o = imm_i;
      end
      OPC_AUIPC, OPC_JAL: begin
        alu_src_a_o = pc_i;
        alu_src_b_o = imm_i;
      end
      OPC_JALR: alu_src_b_o = imm_i;
      OPC_BRANCH: begin
        alu_control_o = ALU_SUB;
        alu_sign_o    = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    nxt_result  = '0;
    nxt_target  = '0;
    nxt_wen     = 1'b0;
    nxt_taken   = 1'b0;
    nxt_illegal = 1'b0;
    case (opcode_i)
      OPC_OP, OPC_OPIMM: begin
        nxt_wen = 1'b1;
        if (funct3_i == F3_SLT)
          nxt_result = {{(XLEN-1){1'b0}}, slt};
        else if (funct3_i == F3_SLTU)
          nxt_result = {{(XLEN-1){1'b0}}, ltu};
        else
          nxt_result = alu_result_i;
      end
      OPC_LUI, OPC_AUIPC: begin
        nxt_wen    = 1'b1;
        nxt_result = alu_result_i;
      end
      OPC_JAL: begin
        nxt_wen    = 1'b1;
        nxt_result = link;
        nxt_taken  = 1'b1;
        nxt_target = pc_imm;
      end
      OPC_JALR: begin
        nxt_wen    = 1'b1;
        nxt_result = link;
        nxt_taken  = 1'b1;
        nxt_target = {alu_result_i[XLEN-1:1], 1'b0};
      end
      OPC_BRANCH: begin
        nxt_illegal = br_illegal;
        nxt_taken   = br_taken & ~br_illegal;
        nxt_target  = nxt_taken ? pc_imm : '0;
      end
      default: nxt_illegal = 1'b1;
    endcase
    if (rd_i == 5'd0)
      nxt_wen = 1'b0;
  end

  assign in_ready_o = ~flush_i & (~out_valid_o | out_ready_i);
  assign accept     = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o <= 1'b0;
      ex_result_o <= '0;
      ex_rd_o     <= '0;
      ex_wen_o    <= 1'b0;
      br_taken_o  <= 1'b0;
      br_target_o <= '0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid_o <= 1'b0;
    end else if (accept) begin
      out_valid_o <= 1'b1;
      ex_result_o <= nxt_result;
      ex_rd_o     <= rd_i;
      ex_wen_o    <= nxt_wen;
      br_taken_o  <= nxt_taken;
      br_target_o <= nxt_target;
      illegal_o   <= nxt_illegal;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

endmodule
